// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage with program counter, synchronous
//            program-memory read port and IF/ID pipeline register. Handles
//            stall (replay of the in-flight word), redirect (flush/refetch)
//            and halt-opcode detection.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int unsigned         PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [7:0]          HALT_OPCODE  = 8'h1F
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [31:0]         if_id_instruction,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic                if_id_valid,
    output logic                halted
);

    localparam logic [0:0]          c_st_fetch  = 1'b0;
    localparam logic [0:0]          c_st_halted = 1'b1;
    localparam logic [PC_WIDTH-1:0] c_pc_one    = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0] r_pc;      // next address to request
    logic [PC_WIDTH-1:0] r_fpc;     // address whose data is on imem_rdata now
    logic                r_fvalid;  // that data is wanted
    logic [0:0]          r_state;
    logic [31:0]         r_if_id_instruction;
    logic [PC_WIDTH-1:0] r_if_id_pc;
    logic                r_if_id_valid;
    logic                r_halted;
    logic                w_halt_hit;

    // Halt opcode seen on a word that is actually wanted.
    assign w_halt_hit = r_fvalid && (imem_rdata[7:0] == HALT_OPCODE);

    // Read address: redirect target first; a stall re-presents the in-flight
    // address so the word returned next cycle is the same one being held.
    always_comb begin
        imem_addr = r_pc;
        if (redirect_valid) begin
            imem_addr = redirect_pc;
        end else if (stall) begin
            imem_addr = r_fpc;
        end
    end

    // PC, fetch tracking, halt FSM and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc                <= RESET_VECTOR;
            r_fpc               <= '0;
            r_fvalid            <= 1'b0;
            r_state             <= c_st_fetch;
            r_if_id_instruction <= '0;
            r_if_id_pc          <= '0;
            r_if_id_valid       <= 1'b0;
            r_halted            <= 1'b0;
        end else if (redirect_valid) begin
            r_if_id_instruction <= '0;
            r_if_id_pc          <= '0;
            r_if_id_valid       <= 1'b0;
            r_fpc               <= redirect_pc;
            r_fvalid            <= 1'b1;
            r_pc                <= redirect_pc + c_pc_one;
            r_state             <= c_st_fetch;
            r_halted            <= 1'b0;
        end else if (stall) begin
            // Everything holds; the in-flight word is replayed via imem_addr.
        end else if (r_state == c_st_fetch) begin
            if (r_fvalid) begin
                r_if_id_instruction <= imem_rdata;
                r_if_id_pc          <= r_fpc;
                r_if_id_valid       <= 1'b1;
            end else begin
                r_if_id_instruction <= '0;
                r_if_id_pc          <= '0;
                r_if_id_valid       <= 1'b0;
            end
            if (w_halt_hit) begin
                // Halt word itself goes to decode; nothing after it is fetched.
                r_state  <= c_st_halted;
                r_halted <= 1'b1;
                r_fvalid <= 1'b0;
            end else begin
                r_fpc    <= r_pc;
                r_fvalid <= 1'b1;
                r_pc     <= r_pc + c_pc_one;
            end
        end else begin
            r_if_id_instruction <= '0;
            r_if_id_pc          <= '0;
            r_if_id_valid       <= 1'b0;
            r_fvalid            <= 1'b0;
        end
    end

    assign if_id_instruction = r_if_id_instruction;
    assign if_id_pc          = r_if_id_pc;
    assign if_id_valid       = r_if_id_valid;
    assign halted            = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage: directed scenarios followed
//            by randomized stall/redirect/reset traffic against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [31:0] if_id_instruction;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    // Small-PC instance for wrap-around, started at 14.
    logic [3:0]  w_addr;
    logic [31:0] w_rdata = '0;
    logic        w_stall = 1'b0;
    logic        w_redir = 1'b0;
    logic [3:0]  w_rpc   = '0;
    logic [31:0] w_instr;
    logic [3:0]  w_pc;
    logic        w_valid;
    logic        w_halted;

    logic [31:0] mem   [0:65535];
    logic [31:0] mem_w [0:15];

    int checks = 0;
    int errors = 0;

    // Reference model state: next address to request, queue of requests
    // whose data is still on its way, and the expected IF/ID contents.
    logic [15:0] m_pc;
    logic [15:0] m_q[$];
    logic [31:0] e_instr;
    logic [15:0] e_pc;
    logic        e_valid;
    logic        e_halted;

    always #5 clk = ~clk;

    fetch_stage #(.PC_WIDTH(16), .RESET_VECTOR(16'h0000), .HALT_OPCODE(8'h1F)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .halted(halted)
    );

    fetch_stage #(.PC_WIDTH(4), .RESET_VECTOR(4'd14), .HALT_OPCODE(8'h1F)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .stall(w_stall), .redirect_valid(w_redir), .redirect_pc(w_rpc),
        .if_id_instruction(w_instr), .if_id_pc(w_pc),
        .if_id_valid(w_valid), .halted(w_halted)
    );

    // Synchronous program memories: data for last cycle's address.
    always @(posedge clk) begin
        imem_rdata <= mem[imem_addr];
        w_rdata    <= mem_w[w_addr];
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        e_instr = '0;
        e_pc    = '0;
        e_valid = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs as driven now.
    task automatic model_step();
        logic [15:0] a;
        logic [31:0] w;
        if (!rst_n) begin
            m_pc = 16'h0000;
            m_q.delete();
            e_halted = 1'b0;
            bubble();
        end else if (redirect_valid) begin
            bubble();
            m_q.delete();
            m_q.push_back(redirect_pc);
            m_pc = redirect_pc + 16'd1;
            e_halted = 1'b0;
        end else if (stall) begin
            // nothing moves
        end else if (e_halted) begin
            bubble();
        end else if (m_q.size() == 0) begin
            bubble();
            m_q.push_back(m_pc);
            m_pc = m_pc + 16'd1;
        end else begin
            a = m_q.pop_front();
            w = mem[a];
            e_instr = w;
            e_pc    = a;
            e_valid = 1'b1;
            if (w[7:0] == 8'h1F) begin
                e_halted = 1'b1;
            end else begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic chk_addr();
        #0;
        if (redirect_valid)
            chk("imem_addr_redirect", 48'(imem_addr), 48'(redirect_pc));
        else if (stall && m_q.size() != 0)
            chk("imem_addr_replay", 48'(imem_addr), 48'(m_q[0]));
        else if (!stall)
            chk("imem_addr_pc", 48'(imem_addr), 48'(m_pc));
    endtask

    task automatic tick();
        chk_addr();
        model_step();
        @(posedge clk);
        #1;
        chk("instr", 48'(if_id_instruction), 48'(e_instr));
        chk("pc", 48'(if_id_pc), 48'(e_pc));
        chk("valid", 48'(if_id_valid), 48'(e_valid));
        chk("halted", 48'(halted), 48'(e_halted));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rw;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        for (int k = 0; k < 65536; k++) mem[k] = 32'(k) * 32'h100 + 32'hBC;
        for (int k = 0; k < 16; k++) mem_w[k] = 32'(k) * 32'h100 + 32'hBC;
        mem[8] = 32'h0000_001F;
        m_pc = '0; e_instr = '0; e_pc = '0; e_valid = 1'b0; e_halted = 1'b0;

        // Reset state.
        tick(); tick();
        chk("rst_instr", 48'(if_id_instruction), 48'h0);
        chk("rst_valid", 48'(if_id_valid), 48'h0);
        chk("rst_halted", 48'(halted), 48'h0);
        chk("rst_addr", 48'(imem_addr), 48'h0);

        // Run from the reset vector; first valid two cycles after release.
        rst_n = 1'b1;
        tick();
        chk("first_bubble", 48'(if_id_valid), 48'h0);
        chk("wrap_first_bubble", 48'(w_valid), 48'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("run_pc", 48'(if_id_pc), 48'(i));
            chk("run_instr", 48'(if_id_instruction), 48'(32'h100 * i + 32'hBC));
            chk("run_valid", 48'(if_id_valid), 48'h1);
            chk("wrap_pc", 48'(w_pc), 48'((14 + i) % 16));
            chk("wrap_instr", 48'(w_instr), 48'(32'h100 * ((14 + i) % 16) + 32'hBC));
        end
        tick(); tick();
        chk("pre_stall_pc", 48'(if_id_pc), 48'h5);

        // Stall three cycles holding pc 5; replay address 6.
        stall = 1'b1;
        #0 chk("stall_addr", 48'(imem_addr), 48'h6);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_pc", 48'(if_id_pc), 48'h5);
            chk("stall_addr_hold", 48'(imem_addr), 48'h6);
        end
        stall = 1'b0;
        tick(); chk("post_stall_6", 48'(if_id_pc), 48'h6);
        tick(); chk("post_stall_7", 48'(if_id_pc), 48'h7);

        // Halt word at 8.
        tick();
        chk("halt_pc", 48'(if_id_pc), 48'h8);
        chk("halt_valid", 48'(if_id_valid), 48'h1);
        chk("halt_instr", 48'(if_id_instruction), 48'h1F);
        chk("halt_flag", 48'(halted), 48'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halted_bubble", 48'(if_id_valid), 48'h0);
            chk("halted_stays", 48'(halted), 48'h1);
        end

        // Redirect out of HALTED.
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        tick();
        chk("unhalt_flag", 48'(halted), 48'h0);
        chk("unhalt_bubble", 48'(if_id_valid), 48'h0);
        redirect_valid = 1'b0;
        tick(); chk("unhalt_pc10", 48'(if_id_pc), 48'h10);
        tick(); chk("unhalt_pc11", 48'(if_id_pc), 48'h11);

        // Redirect while stalled: exactly one bubble.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        tick();
        chk("redir_bubble_valid", 48'(if_id_valid), 48'h0);
        chk("redir_bubble_instr", 48'(if_id_instruction), 48'h0);
        stall = 1'b0; redirect_valid = 1'b0;
        tick(); chk("redir_pc40", 48'(if_id_pc), 48'h40);
        tick(); chk("redir_pc41", 48'(if_id_pc), 48'h41);

        // One-cycle reset mid-stream with stall high.
        stall = 1'b1; rst_n = 1'b0;
        tick();
        chk("midrst_instr", 48'(if_id_instruction), 48'h0);
        chk("midrst_pc", 48'(if_id_pc), 48'h0);
        chk("midrst_valid", 48'(if_id_valid), 48'h0);
        rst_n = 1'b1; stall = 1'b0;
        #0 chk("midrst_addr", 48'(imem_addr), 48'h0);
        tick(); chk("midrst_bubble", 48'(if_id_valid), 48'h0);
        tick(); chk("midrst_pc0", 48'(if_id_pc), 48'h0);
        tick(); chk("midrst_pc1", 48'(if_id_pc), 48'h1);

        // Randomized traffic with random memory contents and halt words.
        rst_n = 1'b0;
        for (int k = 0; k < 65536; k++) begin
            rw = $urandom;
            if ($urandom_range(0, 7) == 0) rw[7:0] = 8'h1F;
            mem[k] = rw;
        end
        tick(); tick();
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65530, 65535))
                                                         : 16'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
